// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEMORY control-word bit positions and MEM-stage FSM encoding.
package pipeline_pkg;

   localparam int MEM_LD   = 0;
   localparam int MEM_ST   = 1;
   localparam int MEM_BYTE = 2;
   localparam int MEM_SEXT = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // A word with both load and store set is executed as a store.
   function automatic logic mem_is_load(input logic ld, input logic st);
      return ld & ~st;
   endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Load-data alignment: picks the addressed byte lane and zero/sign-extends it; word loads pass through.
module mem_byte_align #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rdata,
   input  logic             byte_en,
   input  logic             lane,
   input  logic             sext,
   output logic [WIDTH-1:0] data
);

   logic [7:0] byte_sel;
   logic       fill;

   assign byte_sel = lane ? rdata[15:8] : rdata[7:0];
   assign fill     = sext & byte_sel[7];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi < 8) begin : g_low
            assign data[gi] = byte_en ? byte_sel[gi] : rdata[gi];
         end else begin : g_high
            assign data[gi] = byte_en ? fill : rdata[gi];
         end
      end
   endgenerate

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: runs loads/stores on the data memory over REQ/ACK, stalls the pipe while an
// access is outstanding and emits one registered MEM/WB result per instruction.
module mem_stage_ctrl
   import pipeline_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EXMEM_VALID,
   input  logic [WIDTH-1:0] WRITE_BACK,
   input  logic [WIDTH-1:0] MEMORY,
   input  logic [WIDTH-1:0] REGISTER_VAL1,
   input  logic [WIDTH-1:0] OP1_ADDRESS,
   input  logic [WIDTH-1:0] ALU_RESULT_UPPER,
   input  logic [WIDTH-1:0] ALU_RESULT_LOWER,
   output logic             DMEM_REQ,
   output logic             DMEM_WE,
   output logic             DMEM_BYTE,
   output logic [WIDTH-1:0] DMEM_ADDR,
   output logic [WIDTH-1:0] DMEM_WDATA,
   input  logic [WIDTH-1:0] DMEM_RDATA,
   input  logic             DMEM_ACK,
   output logic             STALL,
   output logic             WB_VALID,
   output logic [WIDTH-1:0] WB_CTRL_OUT,
   output logic [WIDTH-1:0] WB_DATA_OUT,
   output logic [WIDTH-1:0] WB_UPPER_OUT,
   output logic [WIDTH-1:0] WB_DEST_OUT,
   output logic             MEM_ERR
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

   logic             we_reg, byte_reg, sext_reg, ld_reg;
   logic [WIDTH-1:0] addr_reg, wdata_reg, ctrl_reg, upper_reg, dest_reg;

   logic             wb_valid_reg, mem_err_reg;
   logic [WIDTH-1:0] wb_ctrl_reg, wb_data_reg, wb_upper_reg, wb_dest_reg;

   logic             in_mem_op, start, in_access, req, pass_thru;
   logic             ack, timeout, finish;
   logic             cur_we, cur_byte, cur_sext, cur_ld;
   logic [WIDTH-1:0] cur_addr, cur_wdata, cur_ctrl, cur_upper, cur_dest;
   logic [WIDTH-1:0] aligned, result_data;
   logic             mem_bits_unused;

   assign mem_bits_unused = ^MEMORY[WIDTH-1:4];

   // Combinational outputs are gated by reset so they drop the moment RST falls.
   assign in_mem_op = MEMORY[MEM_LD] | MEMORY[MEM_ST];
   assign start     = RST && (state_reg == ST_IDLE) && EXMEM_VALID && in_mem_op;
   assign pass_thru = (state_reg == ST_IDLE) && EXMEM_VALID && !in_mem_op;
   assign in_access = RST && (state_reg == ST_ACCESS);
   assign req       = start | in_access;

   // The entry cycle drives the bus straight from EX/MEM; afterwards the latched copy is used.
   assign cur_we    = start ? MEMORY[MEM_ST]   : we_reg;
   assign cur_byte  = start ? MEMORY[MEM_BYTE] : byte_reg;
   assign cur_sext  = start ? MEMORY[MEM_SEXT] : sext_reg;
   assign cur_ld    = start ? mem_is_load(MEMORY[MEM_LD], MEMORY[MEM_ST]) : ld_reg;
   assign cur_addr  = start ? ALU_RESULT_LOWER : addr_reg;
   assign cur_wdata = start ? REGISTER_VAL1    : wdata_reg;
   assign cur_ctrl  = start ? WRITE_BACK       : ctrl_reg;
   assign cur_upper = start ? ALU_RESULT_UPPER : upper_reg;
   assign cur_dest  = start ? OP1_ADDRESS      : dest_reg;

   // ACK is honoured whenever REQ is up, including a zero-wait ACK in the entry cycle.
   assign cnt_inc = cnt_reg + CNT_W'(1);
   assign ack     = req & DMEM_ACK;
   assign timeout = in_access & ~DMEM_ACK & (cnt_inc == CNT_W'(TIMEOUT));
   assign finish  = ack | timeout;

   mem_byte_align #(.WIDTH(WIDTH)) u_align (
      .rdata   (DMEM_RDATA),
      .byte_en (cur_byte),
      .lane    (cur_addr[0]),
      .sext    (cur_sext),
      .data    (aligned)
   );

   assign result_data = cur_ld ? (timeout ? '0 : aligned) : cur_addr;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = finish ? ST_DONE : ST_ACCESS;
               cnt_next   = '0;
            end
         end
         ST_ACCESS: begin
            cnt_next = cnt_inc;
            if (finish) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         we_reg       <= 1'b0;
         byte_reg     <= 1'b0;
         sext_reg     <= 1'b0;
         ld_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         ctrl_reg     <= '0;
         upper_reg    <= '0;
         dest_reg     <= '0;
         wb_valid_reg <= 1'b0;
         wb_ctrl_reg  <= '0;
         wb_data_reg  <= '0;
         wb_upper_reg <= '0;
         wb_dest_reg  <= '0;
         mem_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         wb_valid_reg <= 1'b0;
         if (start) begin
            we_reg    <= cur_we;
            byte_reg  <= cur_byte;
            sext_reg  <= cur_sext;
            ld_reg    <= cur_ld;
            addr_reg  <= cur_addr;
            wdata_reg <= cur_wdata;
            ctrl_reg  <= cur_ctrl;
            upper_reg <= cur_upper;
            dest_reg  <= cur_dest;
         end
         if (pass_thru) begin
            wb_valid_reg <= 1'b1;
            wb_ctrl_reg  <= WRITE_BACK;
            wb_data_reg  <= ALU_RESULT_LOWER;
            wb_upper_reg <= ALU_RESULT_UPPER;
            wb_dest_reg  <= OP1_ADDRESS;
         end else if (finish) begin
            wb_valid_reg <= 1'b1;
            wb_ctrl_reg  <= cur_ctrl;
            wb_data_reg  <= result_data;
            wb_upper_reg <= cur_upper;
            wb_dest_reg  <= cur_dest;
         end
         if (timeout) begin
            mem_err_reg <= 1'b1;
         end
      end
   end

   assign DMEM_REQ     = req;
   assign DMEM_WE      = req & cur_we;
   assign DMEM_BYTE    = req & cur_byte;
   assign DMEM_ADDR    = req ? cur_addr  : '0;
   assign DMEM_WDATA   = req ? cur_wdata : '0;
   assign STALL        = req;
   assign WB_VALID     = wb_valid_reg;
   assign WB_CTRL_OUT  = wb_ctrl_reg;
   assign WB_DATA_OUT  = wb_data_reg;
   assign WB_UPPER_OUT = wb_upper_reg;
   assign WB_DEST_OUT  = wb_dest_reg;
   assign MEM_ERR      = mem_err_reg;

endmodule
